cmos_axi4s_out_formatter: RTL and testbench



---
 rtl/cmos_axi4s_out_formatter_pkg.sv | 27 ++
 rtl/cmos_axi4s_out_formatter_axis_out_queue.sv | 55 +++++
 rtl/cmos_axi4s_out_formatter.sv | 134 +++++++++++++
 tb/tb_cmos_axi4s_out_formatter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_axi4s_out_formatter_pkg.sv
// Shared definitions for the CMOS AXI4-Stream output formatter:
// FIFO word layout, framing FSM states and the RGB565 to RGB888 expansion.
package cmos_fmt_pkg;

  localparam int PIX_LSB = 0;
  localparam int PIX_MSB = 15;
  localparam int SOF_BIT = 16;
  localparam int EOL_BIT = 17;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } fmt_state_e;

  // Bit replication keeps full-scale components at full scale; the result is in
  // the {R8, B8, G8} order of the downstream video bus.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = pix[15:11];
    g6 = pix[10:5];
    b5 = pix[4:0];
    return {r5, r5[4:2], b5, b5[4:2], g6, g6[5:4]};
  endfunction

endpackage

// File: rtl/cmos_axi4s_out_formatter_axis_out_queue.sv
// Small synchronous FIFO feeding an AXI4-Stream master; exposes its occupancy
// so the producer can throttle its pops early enough.
module axis_out_queue #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 26,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [OCC_W-1:0] occupancy,
  output logic             pop,
  output logic [WIDTH-1:0] tdata,
  output logic             tvalid,
  input  logic             tready
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tvalid    = (occ_reg != '0);
  assign pop       = tvalid && tready;
  // Head is zeroed while empty so the bus reads all-zero out of reset.
  assign tdata     = tvalid ? mem[rd_ptr_reg] : '0;
  assign occupancy = occ_reg;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/cmos_axi4s_out_formatter.sv
// Pops RGB565+SOF/EOL words from the coupler FIFO, realigns to frame starts and
// drives an RGB888 AXI4-Stream video master. Line-length checks need FMT_LINE_CHECK_EN.
module cmos_axi4s_out_formatter
  import cmos_fmt_pkg::*;
#(
  parameter int ACTIVE_WIDTH = 1280,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [17:0] FIFO_RD_DATA,
  input  logic        FIFO_VALID,
  output logic        FIFO_READY,
  output logic [23:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TUSER,
  output logic        M_AXIS_TLAST,
  output logic        FRAME_ERR,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] ERR_CNT
);

  localparam int CNT_W = $clog2(ACTIVE_WIDTH + 1);
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

  logic             s1_valid_reg;
  logic             s1_sof_reg;
  logic             s1_eol_reg;
  logic [23:0]      s1_rgb_reg;
  fmt_state_e       state_reg, state_next;
  logic [CNT_W-1:0] pix_cnt_reg, pix_cnt_next;
  logic             fwd, err, sof_start;
  logic             ready_reg, frame_err_reg;
  logic [15:0]      frame_cnt_reg, err_cnt_reg;
  logic [OCC_W-1:0] q_occ;
  logic             q_pop;
  logic [25:0]      q_data;
  logic [OCC_W:0]   fill_now;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_valid_reg <= 1'b0;
      s1_sof_reg   <= 1'b0;
      s1_eol_reg   <= 1'b0;
      s1_rgb_reg   <= '0;
    end else begin
      // A valid word is already out of the FIFO, so it is always captured.
      s1_valid_reg <= FIFO_VALID;
      if (FIFO_VALID) begin
        s1_sof_reg <= FIFO_RD_DATA[SOF_BIT];
        s1_eol_reg <= FIFO_RD_DATA[EOL_BIT];
        s1_rgb_reg <= rgb565_to_888(FIFO_RD_DATA[PIX_MSB:PIX_LSB]);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pix_cnt_next = pix_cnt_reg;
    fwd          = 1'b0;
    err          = 1'b0;
    sof_start    = 1'b0;
    if (s1_valid_reg) begin
      if (s1_sof_reg) begin
        fwd          = 1'b1;
        sof_start    = 1'b1;
        state_next   = ACTIVE;
        pix_cnt_next = s1_eol_reg ? '0 : CNT_W'(1);
        err          = (state_reg == ACTIVE) && (pix_cnt_reg != '0);
      end else if (state_reg == ACTIVE) begin
`ifdef FMT_LINE_CHECK_EN
        if (s1_eol_reg ? (pix_cnt_reg != CNT_W'(ACTIVE_WIDTH - 1))
                       : (pix_cnt_reg == CNT_W'(ACTIVE_WIDTH))) begin
          err        = 1'b1;
          state_next = WAIT_SOF;
        end else begin
          fwd          = 1'b1;
          pix_cnt_next = s1_eol_reg ? '0 : pix_cnt_reg + 1'b1;
        end
`else
        // Without length checks the counter only records "inside a line".
        fwd          = 1'b1;
        pix_cnt_next = s1_eol_reg ? '0 : CNT_W'(1);
`endif
      end
    end
  end

  // Counting the beat leaving this cycle lets a 4-deep queue sustain 1 word/cycle.
  assign fill_now = {1'b0, q_occ} - {{OCC_W{1'b0}}, q_pop} + {{OCC_W{1'b0}}, s1_valid_reg};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg     <= WAIT_SOF;
      pix_cnt_reg   <= '0;
      ready_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      pix_cnt_reg   <= pix_cnt_next;
      ready_reg     <= (fill_now <= (OCC_W + 1)'(QUEUE_DEPTH - 3));
      frame_err_reg <= err;
      if (sof_start) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      if (err && (err_cnt_reg != 16'hFFFF)) err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  axis_out_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (26)
  ) u_queue (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .push      (fwd),
    .push_data ({s1_sof_reg, s1_eol_reg, s1_rgb_reg}),
    .occupancy (q_occ),
    .pop       (q_pop),
    .tdata     (q_data),
    .tvalid    (M_AXIS_TVALID),
    .tready    (M_AXIS_TREADY)
  );

  assign M_AXIS_TUSER = q_data[25];
  assign M_AXIS_TLAST = q_data[24];
  assign M_AXIS_TDATA = q_data[23:0];
  assign FIFO_READY   = ready_reg;
  assign FRAME_ERR    = frame_err_reg;
  assign FRAME_CNT    = frame_cnt_reg;
  assign ERR_CNT      = err_cnt_reg;

endmodule

// File: tb/tb_cmos_axi4s_out_formatter.sv
// Randomized bench for cmos_axi4s_out_formatter against a queue-based frame model;
// expectations follow FMT_LINE_CHECK_EN when it is defined.
`timescale 1ns/1ps
module tb_cmos_axi4s_out_formatter;

  localparam int AW = 8;
  localparam int QD = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [17:0] FIFO_RD_DATA;
  logic        FIFO_VALID;
  logic        FIFO_READY;
  logic [23:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TUSER;
  logic        M_AXIS_TLAST;
  logic        FRAME_ERR;
  logic [15:0] FRAME_CNT;
  logic [15:0] ERR_CNT;

  always #5 ACLK = ~ACLK;

  cmos_axi4s_out_formatter #(
    .ACTIVE_WIDTH (AW),
    .QUEUE_DEPTH  (QD)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .FIFO_RD_DATA  (FIFO_RD_DATA),
    .FIFO_VALID    (FIFO_VALID),
    .FIFO_READY    (FIFO_READY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .FRAME_ERR     (FRAME_ERR),
    .FRAME_CNT     (FRAME_CNT),
    .ERR_CNT       (ERR_CNT)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [17:0] src_q[$];
  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  bit m_active = 0;
  int m_cnt = 0;
  int m_frames = 0;
  int m_errs = 0;

  function automatic logic [23:0] ref_rgb(input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return {r8[7:0], b8[7:0], g8[7:0]};
  endfunction

  task automatic model_word(input logic [17:0] w);
    bit sof, eol, keep;
    sof = w[16];
    eol = w[17];
    keep = 0;
    if (sof) begin
      if (m_active && m_cnt != 0) m_errs++;
      keep = 1;
      m_active = 1;
      m_frames++;
      m_cnt = eol ? 0 : 1;
    end else if (m_active) begin
`ifdef FMT_LINE_CHECK_EN
      if ((eol && m_cnt + 1 != AW) || (!eol && m_cnt == AW)) begin
        m_errs++;
        m_active = 0;
      end else begin
        keep = 1;
        m_cnt = eol ? 0 : m_cnt + 1;
      end
`else
      keep = 1;
      m_cnt = eol ? 0 : m_cnt + 1;
`endif
    end
    if (keep) exp_q.push_back({sof, eol, ref_rgb(w[15:0])});
  endtask

  function automatic logic [17:0] mk(input bit sof, input bit eol, input logic [15:0] px);
    return {eol, sof, px};
  endfunction

  task automatic send(input logic [17:0] w);
    model_word(w);
    src_q.push_back(w);
  endtask

  task automatic gen_frame(input int lines, input bit with_sof);
    logic [31:0] rnd;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < AW; p++) begin
        rnd = $urandom;
        send(mk(with_sof && l == 0 && p == 0, p == AW - 1, rnd[15:0]));
      end
    end
  endtask

  // ---------------- driver ----------------
  int tready_pct = 100;
  int cyc = 0;
  bit lat_arm = 0;
  int in_cyc = -1;
  int out_cyc = -1;

  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    FIFO_VALID = 1'b0;
    FIFO_RD_DATA = '0;
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      M_AXIS_TREADY = ($urandom_range(99) < tready_pct);
      if (ARESETN && FIFO_READY && src_q.size() > 0) begin
        FIFO_RD_DATA = src_q.pop_front();
        FIFO_VALID = 1'b1;
        if (lat_arm && in_cyc < 0) in_cyc = cyc;
      end else begin
        FIFO_VALID = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit prev_stall = 0;
  logic [25:0] prev_beat;
  logic [25:0] beat;
  int hs_cnt = 0;
  int first_hs = -1;
  int last_hs = -1;
  int err_pulses = 0;
  int rdy_low = 0;

  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        prev_stall = 0;
        continue;
      end
      beat = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
      if (FRAME_ERR) err_pulses++;
      if (!FIFO_READY) rdy_low++;
      if (prev_stall) begin
        check_val("tvalid_hold", M_AXIS_TVALID, 1);
        check_val("beat_hold", beat, prev_beat);
      end
      if (M_AXIS_TVALID && lat_arm && out_cyc < 0) out_cyc = cyc;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        obs_q.push_back(beat);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
        check_val("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_val("beat", beat, exp_q.pop_front());
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_beat = beat;
    end
  end

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      @(posedge ACLK);
      n++;
    end
    check_val({tag, "_drain"}, exp_q.size(), 0);
    repeat (8) @(posedge ACLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tvalid"}, M_AXIS_TVALID, 0);
    check_val({tag, "_ready"}, FIFO_READY, 0);
    check_val({tag, "_tbus"}, {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}, 0);
    check_val({tag, "_ferr"}, FRAME_ERR, 0);
    check_val({tag, "_fcnt"}, FRAME_CNT, 0);
    check_val({tag, "_ecnt"}, ERR_CNT, 0);
  endtask

  logic [23:0] px_exp [4] = '{24'hFF0000, 24'h0000FF, 24'h00FF00, 24'h000000};
  logic [15:0] px_in  [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000};

  initial begin
    int bad_u, bad_l, n, exp_e;
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #2;
    check_reset_outputs("rst");
    @(posedge ACLK);
    #3 ARESETN = 1'b1;

    // Three well-formed frames, TREADY held high.
    first_hs = -1;
    hs_cnt = 0;
    obs_q.delete();
    for (int f = 0; f < 3; f++) gen_frame(4, 1);
    wait_drain("t1");
    check_val("t1_beats", hs_cnt, 96);
    check_val("t1_rate", last_hs - first_hs, 95);
    bad_u = 0;
    bad_l = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i][25] != (i % 32 == 0)) bad_u++;
      if (obs_q[i][24] != (i % 8 == 7)) bad_l++;
    end
    check_val("t1_tuser_pos", bad_u, 0);
    check_val("t1_tlast_pos", bad_l, 0);
    check_val("t1_frame_cnt", FRAME_CNT, 3);
    check_val("t1_err_cnt", ERR_CNT, 0);
    check_val("t1_err_pulses", err_pulses, 0);

    // Colour expansion corner pixels and empty-queue latency.
    obs_q.delete();
    in_cyc = -1;
    out_cyc = -1;
    lat_arm = 1;
    for (int i = 0; i < 4; i++) send(mk(i == 0, 1'b0, px_in[i]));
    for (int i = 4; i < AW; i++) send(mk(1'b0, i == AW - 1, 16'(($urandom))));
    wait_drain("t2");
    lat_arm = 0;
    check_val("t2_latency", out_cyc - in_cyc, 2);
    check_val("t2_beats", obs_q.size(), AW);
    for (int i = 0; i < 4; i++)
      if (i < obs_q.size()) check_val($sformatf("t2_px%0d", i), obs_q[i][23:0], px_exp[i]);

    // Short line: EOL on the fifth pixel, then a clean frame.
    obs_q.delete();
    err_pulses = 0;
    for (int i = 0; i < 5; i++) send(mk(i == 0, i == 4, 16'(($urandom))));
    gen_frame(1, 1);
    wait_drain("t3");
`ifdef FMT_LINE_CHECK_EN
    exp_e = 1;
    n = 4;
    if (obs_q.size() > 4) check_val("t3_next_sof", obs_q[4][25], 1);
`else
    exp_e = 0;
    n = 5;
    if (obs_q.size() > 4) check_val("t3_short_tlast", obs_q[4][24], 1);
`endif
    check_val("t3_err_cnt", ERR_CNT, exp_e);
    check_val("t3_err_pulses", err_pulses, exp_e);
    check_val("t3_beats", obs_q.size(), n + AW);
    check_val("t3_frame_cnt", FRAME_CNT, 16'(m_frames));

    // Random back-pressure at 30% ready.
    obs_q.delete();
    rdy_low = 0;
    tready_pct = 30;
    gen_frame(4, 1);
    gen_frame(4, 1);
    wait_drain("t4");
    tready_pct = 100;
    check_val("t4_beats", obs_q.size(), 64);
    check_val("t4_ready_deassert", rdy_low > 0, 1);
    check_val("t4_err_cnt", ERR_CNT, 16'(m_errs));

    // Reset mid-line, then a stream that starts mid-frame.
    hs_cnt = 0;
    gen_frame(4, 1);
    n = 0;
    while (hs_cnt < 12 && n < 500) begin
      @(posedge ACLK);
      n++;
    end
    check_val("t5_progress", hs_cnt >= 12, 1);
    @(posedge ACLK);
    #3 ARESETN = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    src_q.delete();
    exp_q.delete();
    m_active = 0;
    m_cnt = 0;
    m_frames = 0;
    m_errs = 0;
    repeat (2) @(posedge ACLK);
    #3 ARESETN = 1'b1;
    obs_q.delete();
    err_pulses = 0;
    gen_frame(2, 0);
    gen_frame(4, 1);
    wait_drain("t5");
    check_val("t5_beats", obs_q.size(), 32);
    if (obs_q.size() > 0) check_val("t5_first_tuser", obs_q[0][25], 1);
    check_val("t5_err_pulses", err_pulses, 0);
    check_val("t5_frame_cnt", FRAME_CNT, 1);
    check_val("t5_err_cnt", ERR_CNT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
